// File: rtl/rx_e1_mux_ch_if.sv
// Bus bundle for rx_e1_mux_ch: E1 inputs, controls and the lane/MFI/overflow outputs.
// The slave modport is the mux itself; the master modport is whoever drives the E1 side.
interface rx_e1_mux_ch_if #(
    parameter int CH_NUM   = 42,
    parameter int SLOT_NUM = 16,
    parameter int OUT_GRP  = 3
);
    localparam int MFI_W = $clog2(SLOT_NUM);

    logic                 Sync_In;
    logic [CH_NUM-1:0]    Ch_En;
    logic [CH_NUM-1:0]    E1_In_Dat;
    logic [CH_NUM-1:0]    E1_In_Ck;
    logic                 Ovf_Clr;
    logic [MFI_W-1:0]     E1_MFI;
    logic [2*OUT_GRP-1:0] Dv_Dat;
    logic [CH_NUM-1:0]    Ovf_Flag;

    modport master (
        output Sync_In, Ch_En, E1_In_Dat, E1_In_Ck, Ovf_Clr,
        input  E1_MFI, Dv_Dat, Ovf_Flag
    );

    modport slave (
        input  Sync_In, Ch_En, E1_In_Dat, E1_In_Ck, Ovf_Clr,
        output E1_MFI, Dv_Dat, Ovf_Flag
    );
endinterface

// File: rtl/rx_e1_mux_ch.sv
// RX E1 TDM mux: synchronises CH_NUM E1 data/clock pairs, holds one bit per channel and
// serialises each group of CH_PER_GRP channels onto a {Dv,Dat} lane in a free-running multiframe.
module rx_e1_mux_ch #(
    parameter int CH_NUM     = 42,
    parameter int CH_PER_GRP = 14,
    parameter int SLOT_NUM   = 16,
    parameter int OUT_GRP    = 3
) (
    input logic           Ck,
    input logic           Rs,
    rx_e1_mux_ch_if.slave bus
);
    localparam int MFI_W   = $clog2(SLOT_NUM);
    localparam int GRP_NUM = (CH_NUM + CH_PER_GRP - 1) / CH_PER_GRP;
    localparam int PAD_W   = GRP_NUM * CH_PER_GRP;

    generate
        if (CH_PER_GRP > SLOT_NUM) begin : g_err_grp
            $error("rx_e1_mux_ch: CH_PER_GRP must not exceed SLOT_NUM");
        end
        if (SLOT_NUM < 2 || (SLOT_NUM & (SLOT_NUM - 1)) != 0) begin : g_err_slot
            $error("rx_e1_mux_ch: SLOT_NUM must be a power of two >= 2");
        end
        if (OUT_GRP < GRP_NUM) begin : g_err_lanes
            $error("rx_e1_mux_ch: OUT_GRP too small for CH_NUM/CH_PER_GRP");
        end
    endgenerate

    logic [CH_NUM-1:0]    ck_s1_q, ck_s1_d, ck_s2_q, ck_s2_d;
    logic [CH_NUM-1:0]    dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic [CH_NUM-1:0]    hold_q, hold_d, pend_q, pend_d, ovf_q, ovf_d;
    logic [MFI_W-1:0]     mfi_q, mfi_d, e1_mfi_q, e1_mfi_d;
    logic [2*OUT_GRP-1:0] dv_dat_q, dv_dat_d;
    logic [CH_NUM-1:0]    ch_edge, read_w;
    logic [PAD_W-1:0]     vis_pad, dat_pad;

    always_comb begin
        ck_s1_d  = bus.E1_In_Ck;
        ck_s2_d  = ck_s1_q;
        dat_s1_d = bus.E1_In_Dat;
        dat_s2_d = dat_s1_q;
        mfi_d    = bus.Sync_In ? '0 : mfi_q + 1'b1;

        // A channel is read in the cycle its slot index matches the MFI, in every group at once.
        for (int j = 0; j < CH_NUM; j++) begin
            read_w[j] = (mfi_q == MFI_W'(j % CH_PER_GRP));
        end

        ch_edge = ck_s1_q & ~ck_s2_q & bus.Ch_En;
        hold_d  = (ch_edge & dat_s2_q) | (~ch_edge & hold_q);
        pend_d  = bus.Ch_En & (ch_edge | (pend_q & ~read_w));
        ovf_d   = (ch_edge & pend_q & ~read_w) | (ovf_q & ~{CH_NUM{bus.Ovf_Clr}});
    end

    always_comb begin
        // NOTE: every comb output gets a default before any conditional write, so no latch is inferred.
        vis_pad  = '0;
        dat_pad  = '0;
        dv_dat_d = '0;
        vis_pad[CH_NUM-1:0] = pend_q & bus.Ch_En;
        dat_pad[CH_NUM-1:0] = pend_q & bus.Ch_En & hold_q;

        for (int g = 0; g < GRP_NUM; g++) begin
            for (int s = 0; s < CH_PER_GRP; s++) begin
                if (mfi_q == MFI_W'(s)) begin
                    dv_dat_d[2*g+1] = vis_pad[g*CH_PER_GRP+s];
                    dv_dat_d[2*g]   = dat_pad[g*CH_PER_GRP+s];
                end
            end
        end
        e1_mfi_d = mfi_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge Ck) begin
        if (Rs) begin
            // NOTE: hold bits are cleared too, so no stale data can leak out after reset.
            ck_s1_q  <= '0;
            ck_s2_q  <= '0;
            dat_s1_q <= '0;
            dat_s2_q <= '0;
            hold_q   <= '0;
            pend_q   <= '0;
            ovf_q    <= '0;
            mfi_q    <= '0;
            e1_mfi_q <= '0;
            dv_dat_q <= '0;
        end else begin
            ck_s1_q  <= ck_s1_d;
            ck_s2_q  <= ck_s2_d;
            dat_s1_q <= dat_s1_d;
            dat_s2_q <= dat_s2_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            mfi_q    <= mfi_d;
            e1_mfi_q <= e1_mfi_d;
            dv_dat_q <= dv_dat_d;
        end
    end

    assign bus.E1_MFI   = e1_mfi_q;
    assign bus.Dv_Dat   = dv_dat_q;
    assign bus.Ovf_Flag = ovf_q;
endmodule

// File: tb/tb_rx_e1_mux_ch.sv
// Bench for rx_e1_mux_ch: two configurations share one stimulus stream and are checked every
// cycle against a per-channel mailbox model, plus directed multiframe scenarios.
module tb_rx_e1_mux_ch;
    localparam int NI   = 2;
    localparam int MAXC = 42;

    logic Ck = 1'b0;
    logic Rs;
    always #5 Ck = ~Ck;

    int checks = 0;
    int errors = 0;

    logic            sync_in, clr_in;
    logic [MAXC-1:0] en_in, dat_in, ck_in;

    rx_e1_mux_ch_if #(.CH_NUM(42), .SLOT_NUM(16), .OUT_GRP(3)) bus_a ();
    rx_e1_mux_ch_if #(.CH_NUM(20), .SLOT_NUM(8),  .OUT_GRP(4)) bus_b ();

    assign bus_a.Sync_In   = sync_in;
    assign bus_a.Ovf_Clr   = clr_in;
    assign bus_a.Ch_En     = en_in;
    assign bus_a.E1_In_Dat = dat_in;
    assign bus_a.E1_In_Ck  = ck_in;
    assign bus_b.Sync_In   = sync_in;
    assign bus_b.Ovf_Clr   = clr_in;
    assign bus_b.Ch_En     = en_in[19:0];
    assign bus_b.E1_In_Dat = dat_in[19:0];
    assign bus_b.E1_In_Ck  = ck_in[19:0];

    rx_e1_mux_ch #(.CH_NUM(42), .CH_PER_GRP(14), .SLOT_NUM(16), .OUT_GRP(3)) dut_a (
        .Ck(Ck), .Rs(Rs), .bus(bus_a));
    rx_e1_mux_ch #(.CH_NUM(20), .CH_PER_GRP(8), .SLOT_NUM(8), .OUT_GRP(4)) dut_b (
        .Ck(Ck), .Rs(Rs), .bus(bus_b));

    // Reference model: per channel a one-bit mailbox (waiting flag + bit) and a sticky overflow.
    int   cfg_n [NI] = '{42, 20};
    int   cfg_c [NI] = '{14, 8};
    int   cfg_s [NI] = '{16, 8};
    bit   m_pend [NI][MAXC];
    bit   m_hold [NI][MAXC];
    bit   m_ovf  [NI][MAXC];
    int   m_mfi  [NI];
    logic [7:0] e_dv [NI];
    int   e_mfi  [NI];
    logic [MAXC-1:0] ck_h1, ck_h2, dat_h1, dat_h2;

    int   w_lane = -1, w_cnt, w_mfi, w_dat;
    bit   rnd_phase = 1'b0;
    int   b_bad = 0, b_good = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ovf_vec(input int i);
        logic [63:0] v = '0;
        for (int j = 0; j < cfg_n[i]; j++) v[j] = m_ovf[i][j];
        return v;
    endfunction

    task automatic model_step(input int i);
        int n, c, grp, j;
        bit set;
        logic [7:0] dv;
        n = cfg_n[i];
        c = cfg_c[i];
        grp = (n + c - 1) / c;
        if (Rs) begin
            for (int k = 0; k < MAXC; k++) begin
                m_pend[i][k] = 0; m_hold[i][k] = 0; m_ovf[i][k] = 0;
            end
            m_mfi[i] = 0; e_dv[i] = '0; e_mfi[i] = 0;
            return;
        end
        dv = '0;
        if (m_mfi[i] < c) begin
            for (int g = 0; g < grp; g++) begin
                j = g * c + m_mfi[i];
                if (j < n && en_in[j] && m_pend[i][j]) begin
                    dv[2*g+1] = 1'b1;
                    dv[2*g]   = m_hold[i][j];
                end
            end
        end
        e_dv[i]  = dv;
        e_mfi[i] = m_mfi[i];
        for (j = 0; j < n; j++) begin
            set = 0;
            if (!en_in[j]) m_pend[i][j] = 0;
            else if (ck_h1[j] && !ck_h2[j]) begin
                set = m_pend[i][j] && (j % c != m_mfi[i]);
                m_hold[i][j] = dat_h2[j];
                m_pend[i][j] = 1;
            end else if (j % c == m_mfi[i]) m_pend[i][j] = 0;
            m_ovf[i][j] = set || (m_ovf[i][j] && !clr_in);
        end
        m_mfi[i] = sync_in ? 0 : (m_mfi[i] + 1) % cfg_s[i];
    endtask

    task automatic tick();
        @(posedge Ck);
        for (int i = 0; i < NI; i++) model_step(i);
        if (Rs) begin
            ck_h1 = '0; ck_h2 = '0; dat_h1 = '0; dat_h2 = '0;
        end else begin
            ck_h2 = ck_h1; ck_h1 = ck_in; dat_h2 = dat_h1; dat_h1 = dat_in;
        end
        #1;
        check("a_mfi",  bus_a.E1_MFI,   e_mfi[0]);
        check("a_lane", bus_a.Dv_Dat,   e_dv[0]);
        check("a_ovf",  bus_a.Ovf_Flag, ovf_vec(0));
        check("b_mfi",  bus_b.E1_MFI,   e_mfi[1]);
        check("b_lane", bus_b.Dv_Dat,   e_dv[1]);
        check("b_ovf",  bus_b.Ovf_Flag, ovf_vec(1));
        if (w_lane >= 0 && bus_a.Dv_Dat[2*w_lane+1] === 1'b1) begin
            w_cnt++;
            w_mfi = int'(bus_a.E1_MFI);
            w_dat = int'(bus_a.Dv_Dat[2*w_lane]);
        end
        if (rnd_phase) begin
            if (bus_b.Dv_Dat[7] !== 1'b0 || bus_b.Dv_Dat[6] !== 1'b0) b_bad++;
            if (bus_b.Dv_Dat[5] === 1'b1 && bus_b.E1_MFI >= 4) b_bad++;
            if (bus_b.Dv_Dat[5] === 1'b1 && bus_b.E1_MFI < 4) b_good++;
        end
    endtask

    task automatic wait_mfi(input int v);
        for (int k = 0; k < 40 && m_mfi[0] != v; k++) tick();
    endtask

    task automatic watch_start(input int lane);
        w_lane = lane; w_cnt = 0; w_mfi = -1; w_dat = -1;
    endtask

    initial begin
        Rs = 1'b1; sync_in = 1'b0; clr_in = 1'b0;
        en_in = '1; dat_in = '0; ck_in = '0;
        ck_h1 = '0; ck_h2 = '0; dat_h1 = '0; dat_h2 = '0;

        // Reset, then a full multiframe count from 0.
        repeat (3) tick();
        check("rst_mfi",  bus_a.E1_MFI,   0);
        check("rst_lane", bus_a.Dv_Dat,   0);
        check("rst_ovf",  bus_a.Ovf_Flag, 0);
        Rs = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick();
            check("mfi_seq",  bus_a.E1_MFI, k % 16);
            check("idle_lane", bus_a.Dv_Dat, 0);
        end

        // Channel 15 (lane 1, slot 1): one edge with Dat=1.
        dat_in[15] = 1'b1;
        repeat (2) tick();
        watch_start(1);
        ck_in[15] = 1'b1;
        repeat (3) tick();
        ck_in[15] = 1'b0;
        repeat (40) tick();
        check("ch15_count", w_cnt, 1);
        check("ch15_mfi",   w_mfi, 1);
        check("ch15_dat",   w_dat, 1);

        // Channel 40 (lane 2, slot 12): two edges before slot 12, data 0 then 1.
        wait_mfi(0);
        watch_start(2);
        ck_in[40] = 1'b1;
        repeat (3) tick();
        ck_in[40] = 1'b0; dat_in[40] = 1'b1;
        repeat (3) tick();
        ck_in[40] = 1'b1;
        repeat (3) tick();
        ck_in[40] = 1'b0;
        repeat (30) tick();
        check("ch40_count", w_cnt, 1);
        check("ch40_mfi",   w_mfi, 12);
        check("ch40_dat",   w_dat, 1);
        check("ch40_ovf",   bus_a.Ovf_Flag[40], 1);
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        tick();
        check("ch40_ovf_clr", bus_a.Ovf_Flag, 0);

        // Channel 0 disabled: edges ignored; re-enabled: one edge delivered at slot 0.
        en_in[0] = 1'b0; dat_in[0] = 1'b1;
        watch_start(0);
        repeat (3) begin
            ck_in[0] = 1'b1; repeat (3) tick();
            ck_in[0] = 1'b0; repeat (3) tick();
        end
        repeat (20) tick();
        check("dis_count", w_cnt, 0);
        check("dis_ovf",   bus_a.Ovf_Flag[0], 0);
        en_in[0] = 1'b1;
        repeat (2) tick();
        watch_start(0);
        ck_in[0] = 1'b1;
        repeat (3) tick();
        ck_in[0] = 1'b0;
        repeat (20) tick();
        check("reen_count", w_cnt, 1);
        check("reen_mfi",   w_mfi, 0);

        // Channel 5 edge lands on its own read slot; Sync_In at MFI=9 realigns; bit still delivered.
        dat_in[5] = 1'b1;
        wait_mfi(4);
        watch_start(0);
        ck_in[5] = 1'b1;
        wait_mfi(9);
        ck_in[5] = 1'b0;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("sync_mfi9", bus_a.E1_MFI, 9);
        tick();
        check("sync_mfi0", bus_a.E1_MFI, 0);
        tick();
        check("sync_mfi1", bus_a.E1_MFI, 1);
        repeat (10) tick();
        check("sync_count", w_cnt, 1);
        check("sync_slot",  w_mfi, 5);
        check("sync_dat",   w_dat, 1);
        w_lane = -1;

        // Randomised traffic on all channels, occasional disable, sync and overflow clear.
        rnd_phase = 1'b1;
        for (int k = 0; k < 800; k++) begin
            for (int j = 0; j < MAXC; j++) begin
                if ($urandom_range(19) == 0) ck_in[j] = ~ck_in[j];
                if ($urandom_range(7) == 0)  dat_in[j] = 1'($urandom_range(1));
            end
            if ($urandom_range(63) == 0) en_in[$urandom_range(MAXC - 1)] ^= 1'b1;
            if ($urandom_range(15) == 0) en_in = '1;
            sync_in = ($urandom_range(96) == 0);
            clr_in  = ($urandom_range(36) == 0);
            tick();
        end
        rnd_phase = 1'b0;
        sync_in = 1'b0; clr_in = 1'b0; en_in = '1;
        check("b_idle_slots", b_bad, 0);
        check("b_lane2_used", b_good > 0, 1);

        // Reset with bits pending: nothing may be emitted afterwards.
        ck_in = '0;
        repeat (3) tick();
        dat_in = '1;
        ck_in = '1;
        repeat (3) tick();
        ck_in = '0;
        Rs = 1'b1;
        repeat (2) tick();
        Rs = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("rst_drop_a", bus_a.Dv_Dat, 0);
            check("rst_drop_b", bus_b.Dv_Dat, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
